// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and opcode helpers for the ALU dispatcher.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_LDST = 4'b1000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0111;
   localparam logic [3:0] OP_IDLE = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic is_multicycle(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic is_legal(input logic [3:0] op);
      logic legal;
      case (op)
         OP_ADD, OP_LDST, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR: legal = 1'b1;
         default:                                               legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_md_timer.sv
// Loadable 4-bit down-counter that paces how long the ALU inputs are held.
module alu_md_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       dec_i,
   output logic       zero_o
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != 4'd0))
         cnt_d = cnt_q - 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 4'd0;
      else        cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/alu_dispatch.sv
// Execute-stage front end: holds ALU inputs for the op latency, captures results
// and hands them to writeback over a valid/ready handshake.
module alu_dispatch
   import alu_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int MD_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_rd,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_op1,
   input  logic [WIDTH-1:0] alu_r15,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_rd,
   output logic [WIDTH-1:0] out_r15,
   output logic             out_r15_we,
   output logic             out_err
);

   localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

   state_e           state_q, state_d;
   logic [3:0]       op_q, op_d, rd_q, rd_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             vld_q, vld_d, we_q, we_d, err_q, err_d;
   logic [WIDTH-1:0] res_q, res_d, r15_q, r15_d;
   logic [3:0]       ord_q, ord_d;
   logic             t_load, t_dec, t_zero;
   logic [3:0]       t_load_val;

   alu_md_timer u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (t_load),
      .load_val_i (t_load_val),
      .dec_i      (t_dec),
      .zero_o     (t_zero)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      rd_d       = rd_q;
      vld_d      = vld_q;
      res_d      = res_q;
      r15_d      = r15_q;
      we_d       = we_q;
      err_d      = err_q;
      ord_d      = ord_q;
      in_ready   = 1'b0;
      t_load     = 1'b0;
      t_load_val = 4'd0;
      t_dec      = 1'b0;

      case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_EXEC: begin
            if (t_zero) begin
               state_d = ST_DONE;
               vld_d   = 1'b1;
               ord_d   = rd_q;
               if (!is_legal(op_q)) begin
                  res_d = '0;
                  r15_d = '0;
                  we_d  = 1'b0;
                  err_d = 1'b1;
               end else if ((op_q == OP_DIV) && (b_q == '0)) begin
                  // ALU output is meaningless here; report saturated quotient and dividend
                  res_d = '1;
                  r15_d = a_q;
                  we_d  = 1'b1;
                  err_d = 1'b1;
               end else begin
                  res_d = alu_op1;
                  r15_d = is_multicycle(op_q) ? alu_r15 : '0;
                  we_d  = is_multicycle(op_q);
                  err_d = 1'b0;
               end
            end else begin
               t_dec = 1'b1;
            end
         end
         ST_DONE: begin
            in_ready = out_ready;
            if (out_ready) begin
               vld_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (in_ready && in_valid) begin
         state_d    = ST_EXEC;
         op_d       = in_op;
         a_d        = in_a;
         b_d        = in_b;
         rd_d       = in_rd;
         t_load     = 1'b1;
         t_load_val = is_multicycle(in_op) ? MD_LOAD : 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         rd_q    <= 4'd0;
         vld_q   <= 1'b0;
         res_q   <= '0;
         r15_q   <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         ord_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rd_q    <= rd_d;
         vld_q   <= vld_d;
         res_q   <= res_d;
         r15_q   <= r15_d;
         we_q    <= we_d;
         err_q   <= err_d;
         ord_q   <= ord_d;
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_ctrl   = (state_q == ST_EXEC) ? op_q : OP_IDLE;
   assign out_valid  = vld_q;
   assign out_result = res_q;
   assign out_r15    = r15_q;
   assign out_r15_we = we_q;
   assign out_err    = err_q;
   assign out_rd     = ord_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized + directed bench for alu_dispatch against a behavioural result/latency model.
module tb_alu_dispatch;

   localparam int W  = 16;
   localparam int MD = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0, in_ready;
   logic [3:0]   in_op = 4'd0, in_rd = 4'd0;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic [W-1:0] alu_a, alu_b, alu_op1, alu_r15;
   logic [3:0]   alu_ctrl;
   logic         out_valid, out_ready = 1'b0, out_r15_we, out_err;
   logic [W-1:0] out_result, out_r15;
   logic [3:0]   out_rd;

   int checks = 0, failures = 0, cyc = 0;

   alu_dispatch #(.WIDTH(W), .MD_CYCLES(MD)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_op1(alu_op1), .alu_r15(alu_r15),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_rd(out_rd), .out_r15(out_r15), .out_r15_we(out_r15_we), .out_err(out_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Combinational ALU stand-in; unused result lanes carry junk so the DUT must mask them.
   always_comb begin
      alu_op1 = 16'hBAD0;
      alu_r15 = 16'h0BAD;
      case (alu_ctrl)
         4'b0000, 4'b1000: begin alu_op1 = alu_a + alu_b; alu_r15 = 16'h0; end
         4'b0001: begin alu_op1 = alu_a - alu_b; alu_r15 = 16'h0; end
         4'b0010: {alu_r15, alu_op1} = 32'(alu_a) * 32'(alu_b);
         4'b0011: if (alu_b != 16'h0) begin alu_op1 = alu_a / alu_b; alu_r15 = alu_a % alu_b; end
         4'b0100: begin alu_op1 = alu_a & alu_b; alu_r15 = 16'h0; end
         4'b0111: begin alu_op1 = alu_a | alu_b; alu_r15 = 16'h0; end
         default: alu_r15 = 16'h0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected writeback bundle and capture latency, straight from the op semantics.
   task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output logic [15:0] r15,
                        output logic we, output logic err, output int lat);
      int unsigned ua, ub, p;
      ua = a; ub = b;
      res = 16'h0; r15 = 16'h0; we = 1'b0; err = 1'b0; lat = 1;
      case (op)
         4'd0, 4'd8: res = 16'((ua + ub) % 65536);
         4'd1:       res = 16'((ua + 65536 - ub) % 65536);
         4'd4:       res = a & b;
         4'd7:       res = a | b;
         4'd2: begin
            p = ua * ub;
            res = 16'(p % 65536); r15 = 16'(p / 65536); we = 1'b1; lat = MD;
         end
         4'd3: begin
            we = 1'b1; lat = MD;
            if (ub == 0) begin res = 16'hFFFF; r15 = a; err = 1'b1; end
            else begin res = 16'(ua / ub); r15 = 16'(ua % ub); end
         end
         default: err = 1'b1;
      endcase
   endtask

   // Issue one op (also releases any result currently presented), check its execution
   // window and result, then hold the result for `stall` cycles with out_ready low.
   task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] rd, input int stall);
      logic [15:0] e_res, e_r15;
      logic        e_we, e_err;
      int          e_lat, acc, k;
      bit          seen;
      model(op, a, b, e_res, e_r15, e_we, e_err, e_lat);
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd; out_ready = 1'b1;
      #1 chk("in_ready_accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 acc = cyc;
      in_valid = 1'b0; out_ready = 1'b0;
      seen = 1'b0;
      for (k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
         else begin
            chk("alu_a_hold", 32'(alu_a), 32'(a));
            chk("alu_b_hold", 32'(alu_b), 32'(b));
            chk("alu_ctrl_hold", 32'(alu_ctrl), 32'(op));
         end
      end
      if (!seen) begin
         chk("out_valid_timeout", 32'd0, 32'd1);
         return;
      end
      chk("latency", 32'(cyc - acc), 32'(e_lat));
      chk("out_result", 32'(out_result), 32'(e_res));
      chk("out_r15", 32'(out_r15), 32'(e_r15));
      chk("out_r15_we", 32'(out_r15_we), 32'(e_we));
      chk("out_err", 32'(out_err), 32'(e_err));
      chk("out_rd", 32'(out_rd), 32'(rd));
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_result", 32'(out_result), 32'(e_res));
         chk("stall_r15", 32'(out_r15), 32'(e_r15));
         chk("stall_ctrl_idle", 32'(alu_ctrl), 32'hF);
      end
   endtask

   task automatic drain();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      chk("drain_valid", 32'(out_valid), 32'd0);
      chk("drain_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_err"}, 32'(out_err), 32'd0);
      chk({tag, "_we"}, 32'(out_r15_we), 32'd0);
      chk({tag, "_result"}, 32'(out_result), 32'd0);
      chk({tag, "_r15"}, 32'(out_r15), 32'd0);
      chk({tag, "_rd"}, 32'(out_rd), 32'd0);
      chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
      chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
      chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'hF);
   endtask

   logic [3:0] legal_ops [7] = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7};

   initial begin
      logic [3:0]  rop;
      logic [15:0] ra, rb;
      #12 chk_reset_vals("reset");
      @(negedge clk) rst_n = 1'b1;

      do_op(4'b0000, 16'h0003, 16'h0004, 4'd1, 0);
      do_op(4'b0010, 16'h1234, 16'h0100, 4'd2, 1);
      do_op(4'b0011, 16'd100,  16'd7,    4'd3, 0);
      do_op(4'b0011, 16'h0055, 16'h0000, 4'd4, 5);
      do_op(4'b0001, 16'd9,    16'd12,   4'd5, 0);
      do_op(4'b0101, 16'h1111, 16'h2222, 4'd6, 2);
      drain();

      // Async reset two cycles into a multiply must drop the op immediately.
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'b0010; in_a = 16'h00FF; in_b = 16'h0101; in_rd = 4'd9;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midreset");
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < MD + 3; i++) begin
         @(negedge clk);
         chk("post_reset_no_valid", 32'(out_valid), 32'd0);
      end

      for (int n = 0; n < 60; n++) begin
         rop = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 6)]
                                          : 4'($urandom_range(0, 15));
         ra  = 16'($urandom);
         rb  = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
         do_op(rop, ra, rb, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d exp=finish", cyc);
      $fatal(1, "bench timed out");
   end

endmodule
